mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (fetch + data) arbiter in front of a single-port memory, three cycles per access.
// Define MEM_ARB_RR_EN for round-robin selection; otherwise the data port has fixed priority.
module mem_arbiter #(
  parameter int unsigned AW = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {
    StIdle,
    StAccI,
    StAccD,
    StRespI,
    StRespD
  } state_e;

  state_e state;
  logic   grant_d;
  logic   addr_err;

`ifdef MEM_ARB_RR_EN
  logic prefer_d;  // set when the fetch port was served last

  assign grant_d = d_req & (~i_req | prefer_d);
`else
  assign grant_d = d_req;
`endif

  // mem_addr holds the in-flight address for the whole access cycle
  assign addr_err = |mem_addr[31:AW];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= StIdle;
      i_ack    <= 1'b0;
      d_ack    <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
      mem_ren  <= 1'b0;
      mem_wen  <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
`ifdef MEM_ARB_RR_EN
      prefer_d <= 1'b1;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          if (i_req || d_req) begin
            busy <= 1'b1;
`ifdef MEM_ARB_RR_EN
            prefer_d <= ~grant_d;
`endif
            if (grant_d) begin
              state    <= StAccD;
              mem_ren  <= ~d_we;
              mem_wen  <= d_we;
              mem_addr <= d_addr;
              mem_din  <= d_wdata;
            end else begin
              state    <= StAccI;
              mem_ren  <= 1'b1;
              mem_wen  <= 1'b0;
              mem_addr <= i_addr;
            end
          end
        end
        StAccI: begin
          state   <= StRespI;
          mem_ren <= 1'b0;
          i_ack   <= 1'b1;
          i_rdata <= mem_dout;
          if (addr_err) err <= 1'b1;
        end
        StAccD: begin
          state   <= StRespD;
          mem_ren <= 1'b0;
          mem_wen <= 1'b0;
          d_ack   <= 1'b1;
          if (mem_ren) d_rdata <= mem_dout;
          if (addr_err) err <= 1'b1;
        end
        StRespI: begin
          state <= StIdle;
          i_ack <= 1'b0;
          busy  <= 1'b0;
        end
        StRespD: begin
          state <= StIdle;
          d_ack <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state   <= StIdle;
          mem_ren <= 1'b0;
          mem_wen <= 1'b0;
          i_ack   <= 1'b0;
          d_ack   <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model checked every cycle plus directed vectors.
module tb_mem_arbiter;
  localparam int unsigned Aw = 10;
`ifdef MEM_ARB_RR_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic        i_ack, d_ack, mem_ren, mem_wen, busy, err;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_din, mem_dout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  mem_arbiter #(.AW(Aw)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .busy(busy), .err(err)
  );

  // Environment memory: combinational read, write on negedge.
  logic [31:0] mem [256];
  assign mem_dout = mem[mem_addr[Aw-1:2]];
  initial forever begin
    @(negedge clock);
    if (mem_wen) mem[mem_addr[Aw-1:2]] = mem_din;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Model: one outstanding transaction; access cycle is the one after the grant edge,
  // response the cycle after that, then one idle cycle before the next grant.
  logic [31:0] ref_mem [256];
  bit          tx_on, tx_d, tx_we, last_i, m_err;
  logic [31:0] tx_addr, tx_wdata, m_irdata, m_drdata;
  int          cyc, tx_t;
  int          wen_cnt = 0, iack_cnt = 0, dack_cnt = 0;
  bit          ack_log [$];

  initial forever begin
    @(negedge clock);
    if (!reset) begin
      tx_on = 0; m_err = 0; m_irdata = '0; m_drdata = '0; cyc = 0; tx_t = 0; last_i = 1;
    end else begin : step
      bit acc, rsp, take_d;
      int ph;
      cyc++;
      ph  = cyc - tx_t;
      acc = tx_on && ph == 0;
      rsp = tx_on && ph == 1;
      if (rsp) begin
        if (tx_addr[31:Aw] != 0) m_err = 1;
        if (!tx_d) m_irdata = ref_mem[tx_addr[Aw-1:2]];
        else if (!tx_we) m_drdata = ref_mem[tx_addr[Aw-1:2]];
      end
      check("busy", busy, acc || rsp);
      check("mem_ren", mem_ren, acc && (!tx_d || !tx_we));
      check("mem_wen", mem_wen, acc && tx_d && tx_we);
      check("i_ack", i_ack, rsp && !tx_d);
      check("d_ack", d_ack, rsp && tx_d);
      check("err", err, m_err);
      check("i_rdata", i_rdata, m_irdata);
      check("d_rdata", d_rdata, m_drdata);
      if (acc) check("mem_addr", mem_addr, tx_addr);
      if (acc && tx_d && tx_we) begin
        check("mem_din", mem_din, tx_wdata);
        ref_mem[tx_addr[Aw-1:2]] = tx_wdata;
      end
      if (mem_wen) wen_cnt++;
      if (i_ack) begin iack_cnt++; ack_log.push_back(1'b0); end
      if (d_ack) begin dack_cnt++; ack_log.push_back(1'b1); end
      if (!acc && !rsp && (i_req || d_req)) begin
        take_d   = d_req && (!i_req || !RrEn || last_i);
        last_i   = !take_d;
        tx_on    = 1;
        tx_t     = cyc + 1;
        tx_d     = take_d;
        tx_we    = take_d && d_we;
        tx_addr  = take_d ? d_addr : i_addr;
        tx_wdata = d_wdata;
      end
    end
  end

  task automatic do_access(input bit is_d, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata,
                           output int lat);
    if (is_d) begin d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata; end
    else begin i_req = 1; i_addr = addr; end
    lat   = 0;
    rdata = 'x;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clock); #1;
      if (is_d ? d_ack : i_ack) begin
        lat   = n;
        rdata = is_d ? d_rdata : i_rdata;
        break;
      end
    end
    @(posedge clock); #1;
    if (is_d) begin d_req = 0; d_we = 0; end
    else i_req = 0;
  endtask

  task automatic apply_reset();
    @(posedge clock); #1;
    reset = 0;
    @(posedge clock); #1;
    reset = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, rd2;
    int          lat, lat2, w0, d0, i0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = (i * 32'h0101_0101) ^ 32'h5A5A_0000;
      ref_mem[i] = mem[i];
    end
    mem[4] = 32'hCAFE_0004; ref_mem[4] = 32'hCAFE_0004;
    mem[8] = 32'hAAAA_5555; ref_mem[8] = 32'hAAAA_5555;

    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_ren", mem_ren, 0);
    check("rst_wen", mem_wen, 0);
    check("rst_i_ack", i_ack, 0);
    check("rst_d_ack", d_ack, 0);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_din", mem_din, 0);
    reset = 1;

    // Single fetch
    do_access(0, 0, 32'h10, 0, rd, lat);
    check("fetch_lat", lat, 2);
    check("fetch_data", rd, 32'hCAFE_0004);

    // Write then read
    w0 = wen_cnt;
    do_access(1, 1, 32'h8, 32'h1234_5678, rd, lat);
    check("wr_lat", lat, 2);
    do_access(1, 0, 32'h8, 0, rd, lat);
    check("rd_lat", lat, 2);
    check("rd_data", rd, 32'h1234_5678);
    check("wr_wen_pulses", wen_cnt - w0, 1);

    // Simultaneous requests right after reset: data port first either way
    apply_reset();
    fork
      do_access(1, 0, 32'h8, 0, rd, lat);
      do_access(0, 0, 32'h10, 0, rd2, lat2);
    join
    check("sim_d_lat", lat, 2);
    check("sim_i_lat", lat2, 5);
    check("sim_d_data", rd, 32'h1234_5678);
    check("sim_i_data", rd2, 32'hCAFE_0004);

    // Continuous requests on both ports
    apply_reset();
    ack_log.delete();
    i_addr = 32'h10; d_addr = 32'h14; d_we = 0;
    i_req = 1; d_req = 1;
    repeat (12) @(posedge clock);
    #1;
    i_req = 0; d_req = 0;
    check("cont_ack_count", ack_log.size(), 4);
    for (int i = 0; i < 4 && i < ack_log.size(); i++)
      check($sformatf("cont_grant_%0d", i), ack_log[i], RrEn ? (i % 2 == 0) : 1'b1);

    // Addressing error is sticky
    do_access(1, 0, 32'h0000_1000, 0, rd, lat);
    check("err_lat", lat, 2);
    check("err_set", err, 1);
    do_access(0, 0, 32'h10, 0, rd, lat);
    check("err_sticky", err, 1);
    check("err_fetch_data", rd, 32'hCAFE_0004);

    // Reset during a write access
    d0 = dack_cnt;
    d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF;
    @(posedge clock); #1;
    check("midw_wen_active", mem_wen, 1);
    reset = 0;
    #1;
    check("midw_wen_drop", mem_wen, 0);
    check("midw_busy", busy, 0);
    check("midw_d_ack", d_ack, 0);
    d_req = 0; d_we = 0;
    @(posedge clock); #1;
    reset = 1;
    repeat (3) @(posedge clock);
    #1;
    check("midw_word", mem[8], 32'hAAAA_5555);
    check("midw_no_ack", dack_cnt, d0);
    check("midw_err_clr", err, 0);

    // Fetch request withdrawn during the access
    i0 = iack_cnt;
    i_req = 1; i_addr = 32'h10;
    @(posedge clock); #1;
    i_req = 0;
    repeat (4) @(posedge clock);
    #1;
    check("wd_ack_once", iack_cnt - i0, 1);
    check("wd_idle", busy, 0);
    check("wd_data", i_rdata, 32'hCAFE_0004);

    repeat (3) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
